// File: rtl/sensor_scan_sched_pkg.sv
// Shared types for the sensor scan scheduler: FSM states and channel indices.
package sensor_scan_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_WAIT,
    S_CAM
  } scan_state_t;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_SOIL     = 2'd0;
  localparam chan_t CH_TEMP     = 2'd1;
  localparam chan_t CH_HUMIDITY = 2'd2;
  localparam chan_t CH_LIGHT    = 2'd3;

endpackage

// File: rtl/scan_chan_pick.sv
// Finds the lowest enabled channel above from_chan (or at it, when incl is set).
module scan_chan_pick
  import sensor_scan_sched_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] from_chan,
  input  logic       incl,
  output logic [1:0] next_chan,
  output logic       none_left
);

  always_comb begin
    next_chan = from_chan;
    none_left = 1'b1;
    // Descending walk so the lowest qualifying channel wins.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from_chan)) || (incl && (i == int'(from_chan))))) begin
        next_chan = chan_t'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_sched.sv
// Periodic ADC channel scanner with deferred camera-ownership handoff.
// Define SCAN_WATCHDOG_EN to add the adc_ack timeout watchdog and sticky err_timeout.
//
// state     | meaning
// S_IDLE    | not scanning, waiting for scan_en or cam_req
// S_REQ     | adc_req high on adc_chan, waiting for adc_ack
// S_RELEASE | adc_req low, waiting for adc_ack to fall
// S_WAIT    | inter-round idle countdown
// S_CAM     | camera owns the sensor bus
module sensor_scan_sched
  import sensor_scan_sched_pkg::*;
#(
  parameter int INTERVAL_W  = 16,
  parameter int ACK_TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic [3:0]            chan_mask,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  adc_req,
  input  logic                  adc_ack,
  output logic [1:0]            adc_chan,
  input  logic [7:0]            adc_data,
  output logic                  sample_valid,
  output logic [1:0]            sample_chan,
  output logic [7:0]            sample_data,
  input  logic                  cam_req,
  input  logic                  frame_done,
  output logic                  cam_grant,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam logic [INTERVAL_W-1:0] INT_ONE = INTERVAL_W'(1);

  scan_state_t           state_q, state_d;
  chan_t                 chan_q, chan_d;
  logic [3:0]            mask_q, mask_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  sample_valid_d;
  chan_t                 sample_chan_d;
  logic [7:0]            sample_data_d;
  logic                  launch, time_out, mask_any;
  chan_t                 next_chan, first_chan;
  logic                  last_chan, first_none;

`ifdef SCAN_WATCHDOG_EN
  localparam int WD_W = $clog2(ACK_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(ACK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  assign mask_any = |chan_mask;

  scan_chan_pick u_pick_next (
    .mask      (mask_q),
    .from_chan (chan_q),
    .incl      (1'b0),
    .next_chan (next_chan),
    .none_left (last_chan)
  );

  scan_chan_pick u_pick_first (
    .mask      (chan_mask),
    .from_chan (CH_SOIL),
    .incl      (1'b1),
    .next_chan (first_chan),
    .none_left (first_none)
  );

  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    sample_valid_d = 1'b0;
    sample_chan_d  = sample_chan;
    sample_data_d  = sample_data;
    launch         = 1'b0;
    time_out       = 1'b0;
`ifdef SCAN_WATCHDOG_EN
    wd_d           = '0;
    err_d          = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cam_req) state_d = S_CAM;
        else         launch  = scan_en && mask_any;
      end
      S_REQ: begin
        if (adc_ack) begin
          sample_valid_d = 1'b1;
          sample_chan_d  = chan_q;
          sample_data_d  = adc_data;
          state_d        = S_RELEASE;
        end
`ifdef SCAN_WATCHDOG_EN
        else if (wd_q == WD_LIMIT) time_out = 1'b1;
        else                       wd_d     = wd_q + WD_ONE;
`endif
      end
      S_RELEASE: begin
        if (!adc_ack) begin
          if (!last_chan) begin
            chan_d  = next_chan;
            state_d = S_REQ;
          end else if (cam_req) begin
            state_d = S_CAM;
          end else if (!scan_en) begin
            state_d = S_IDLE;
          end else if (interval == '0) begin
            // Zero interval: next round starts straight away, no WAIT cycle.
            state_d = S_IDLE;
            launch  = mask_any;
          end else begin
            state_d = S_WAIT;
            cnt_d   = interval - INT_ONE;
          end
        end
`ifdef SCAN_WATCHDOG_EN
        else if (wd_q == WD_LIMIT) time_out = 1'b1;
        else                       wd_d     = wd_q + WD_ONE;
`endif
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (cam_req) begin
            state_d = S_CAM;
          end else begin
            state_d = S_IDLE;
            launch  = scan_en && mask_any;
          end
        end else begin
          cnt_d = cnt_q - INT_ONE;
        end
      end
      S_CAM: begin
        if (frame_done || !cam_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New round: mask is captured here and held until the round ends.
    if (launch && !first_none) begin
      state_d = S_REQ;
      mask_d  = chan_mask;
      chan_d  = first_chan;
    end

    if (time_out) begin
`ifdef SCAN_WATCHDOG_EN
      err_d   = 1'b1;
`endif
      state_d = S_WAIT;
      cnt_d   = (interval == '0) ? '0 : (interval - INT_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chan_q       <= CH_SOIL;
      mask_q       <= '0;
      cnt_q        <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= CH_SOIL;
      sample_data  <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      sample_valid <= sample_valid_d;
      sample_chan  <= sample_chan_d;
      sample_data  <= sample_data_d;
    end
  end

`ifdef SCAN_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  // No watchdog: flag is constant low; the comparison only keeps ACK_TIMEOUT referenced.
  assign err_timeout = (ACK_TIMEOUT < 0);
`endif

  assign adc_req   = (state_q == S_REQ);
  assign adc_chan  = chan_q;
  assign cam_grant = (state_q == S_CAM);
  assign busy      = (state_q == S_REQ) || (state_q == S_RELEASE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Randomized self-checking bench for sensor_scan_sched against a round-level reference.
module tb_sensor_scan_sched;

  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_en;
  logic [3:0]    chan_mask;
  logic [IW-1:0] interval;
  logic          adc_req;
  logic          adc_ack;
  logic [1:0]    adc_chan;
  logic [7:0]    adc_data;
  logic          sample_valid;
  logic [1:0]    sample_chan;
  logic [7:0]    sample_data;
  logic          cam_req;
  logic          frame_done;
  logic          cam_grant;
  logic          busy;
  logic          err_timeout;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]    cfg_mask;
  logic [IW-1:0] cfg_int;

  always #5 clk = ~clk;

  sensor_scan_sched #(.INTERVAL_W(IW), .ACK_TIMEOUT(63)) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en),
    .chan_mask    (chan_mask),
    .interval     (interval),
    .adc_req      (adc_req),
    .adc_ack      (adc_ack),
    .adc_chan     (adc_chan),
    .adc_data     (adc_data),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .cam_req      (cam_req),
    .frame_done   (frame_done),
    .cam_grant    (cam_grant),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ADC handshake on the expected channel, after exp_gap idle cycles.
  // action: 1 load next config, 2 raise cam_req, 3 drop scan_en (applied once the request is seen).
  task automatic serve(input int exp_chan, input int exp_gap, input int action);
    int gap = 0;
    int dly = $urandom_range(0, 3);
    int hold = $urandom_range(0, 2);
    logic [7:0] d;
    while (adc_req !== 1'b1 && gap < 200) begin
      tick();
      gap++;
    end
    chk("req_gap", gap, exp_gap);
    chk("adc_chan", adc_chan, exp_chan);
    chk("busy_req", busy, 1);
    case (action)
      1: begin chan_mask = cfg_mask; interval = cfg_int; end
      2: cam_req = 1'b1;
      3: scan_en = 1'b0;
      default: ;
    endcase
    repeat (dly) begin
      tick();
      chk("req_hold", {adc_req, adc_chan, sample_valid}, {1'b1, 2'(exp_chan), 1'b0});
    end
    d = 8'($urandom);
    adc_data = d;
    adc_ack = 1'b1;
    tick();
    chk("sample_valid", sample_valid, 1);
    chk("sample_chan", sample_chan, exp_chan);
    chk("sample_data", sample_data, d);
    chk("req_drop", adc_req, 0);
    repeat (hold) begin
      tick();
      chk("sv_pulse", sample_valid, 0);
      chk("req_low", adc_req, 0);
    end
    adc_ack = 1'b0;
    adc_data = 8'($urandom);
    tick();
  endtask

  // Reference: a round visits the set bits of its mask in ascending order, back to back.
  task automatic run_round(input logic [3:0] m, input int first_gap, input int action);
    int k = 0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        serve(c, (k == 0) ? first_gap : 0, (k == 0) ? action : 0);
        k++;
      end
    end
  endtask

  logic [3:0]    tbl_mask [6] = '{4'b1111, 4'b1010, 4'b1010, 4'b0001, 4'b0001, 4'b0001};
  logic [IW-1:0] tbl_int  [6] = '{16'd3, 16'd2, 16'd0, 16'd0, 16'd0, 16'd1};

  initial begin
    logic [3:0] cur_mask;
    int         gap;
    int         g;

    rst = 1'b1; scan_en = 1'b0; chan_mask = 4'b0; interval = 16'd3;
    adc_ack = 1'b0; adc_data = 8'h0; cam_req = 1'b0; frame_done = 1'b0;
    #12;
    chk("reset_outputs", {adc_req, adc_chan, sample_valid, sample_chan, sample_data,
                          cam_grant, busy, err_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_quiet", {adc_req, busy, cam_grant}, 0);

    // Directed rounds first, then randomized masks and intervals.
    chan_mask = 4'b1111;
    interval  = 16'd3;
    scan_en   = 1'b1;
    cur_mask  = 4'b1111;
    gap       = 1;
    for (int r = 0; r < 18; r++) begin
      if (r < 6) begin
        cfg_mask = tbl_mask[r];
        cfg_int  = tbl_int[r];
      end else begin
        cfg_mask = 4'($urandom_range(1, 15));
        cfg_int  = IW'($urandom_range(0, 4));
      end
      run_round(cur_mask, gap, 1);
      cur_mask = cfg_mask;
      gap      = int'(cfg_int);
    end

    // scan_en dropped mid-round: round finishes, then idle.
    run_round(cur_mask, gap, 3);
    chk("scan_off_busy", busy, 0);
    repeat (5) tick();
    chk("scan_off_quiet", {adc_req, busy}, 0);

    // Camera request during channel 1 is deferred to round end.
    chan_mask = 4'b1111;
    interval  = 16'd5;
    scan_en   = 1'b1;
    serve(0, 1, 0);
    serve(1, 0, 2);
    serve(2, 0, 0);
    serve(3, 0, 0);
    chk("cam_grant_now", {cam_grant, busy, adc_req}, 3'b100);
    repeat (3) tick();
    chk("cam_grant_hold", cam_grant, 1);
    frame_done = 1'b1;
    tick();
    chk("cam_frame_done", {cam_grant, busy}, 0);
    frame_done = 1'b0;
    cam_req = 1'b0;
    run_round(4'b1111, 1, 3);
    chk("post_cam_idle", busy, 0);

    // Camera from idle, released by cam_req falling.
    cam_req = 1'b1;
    tick();
    chk("cam_from_idle", {cam_grant, busy}, 2'b10);
    cam_req = 1'b0;
    tick();
    chk("cam_release", cam_grant, 0);

    // Stalled acknowledge.
    chan_mask = 4'b0100;
    interval  = 16'd2;
    scan_en   = 1'b1;
    tick();
    chk("stall_req", {adc_req, adc_chan}, 3'b110);
`ifdef SCAN_WATCHDOG_EN
    repeat (63) tick();
    chk("wd_not_yet", {err_timeout, adc_req}, 2'b01);
    tick();
    chk("wd_fired", {err_timeout, adc_req, busy, sample_valid}, 4'b1010);
`else
    repeat (80) tick();
    chk("no_wd_stays", {adc_req, err_timeout, adc_chan}, 4'b1010);
`endif

    // Asynchronous reset in the middle of a handshake.
    g = 0;
    while (adc_req !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("rst_pre_req", adc_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {adc_req, adc_chan, sample_valid, sample_chan, sample_data,
                      cam_grant, busy, err_timeout}, 0);
    adc_ack = 1'b1;
    scan_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_sample", {sample_valid, adc_req}, 0);
    end
    adc_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
